// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and state encoding for the 3x3 window feeder.
package conv_window_feeder_pkg;

  localparam int KSIZE     = 3;
  localparam int WIN_ELEMS = KSIZE * KSIZE;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/conv_window_feeder_line_buf.sv
// One image row of storage: synchronous write, asynchronous read
// at the same column index so the old value can be forwarded.
module line_buf #(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int aw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    idx,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x3 sliding window, valid/ready on both
// sides, one window per cycle when the consumer keeps up.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int img_w = 8,
  parameter int img_h = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [width-1:0]           pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [WIN_ELEMS*width-1:0] win,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       frame_done
);

  localparam int CW = $clog2(img_w);
  localparam int RW = $clog2(img_h);
  localparam logic [CW-1:0] COL_LAST = CW'(img_w - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_h - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(KSIZE - 2);

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WIN_ELEMS-1:0][width-1:0] win_q, win_d;
  logic win_valid_q, win_valid_d;
  logic win_last_q, win_last_d;

  logic [width-1:0] lb1_rd;
  logic [width-1:0] lb2_rd;
  logic acc;
  logic col_end;
  logic row_end;
  logic qual;

  assign pix_ready = !win_valid_q || win_ready;
  assign acc       = pix_valid && pix_ready;
  assign col_end   = col_q == COL_LAST;
  assign row_end   = row_q == ROW_LAST;
  assign qual      = (state_q == S_RUN) && (col_q >= COL_MIN);

  // lb1 holds row-1, lb2 holds row-2; lb1's old entry cascades into lb2
  line_buf #(
    .width(width),
    .depth(img_w)
  ) u_lb1 (
    .clk  (clk),
    .we   (acc),
    .idx  (col_q),
    .wdata(pix_in),
    .rdata(lb1_rd)
  );

  line_buf #(
    .width(width),
    .depth(img_w)
  ) u_lb2 (
    .clk  (clk),
    .we   (acc),
    .idx  (col_q),
    .wdata(lb1_rd),
    .rdata(lb2_rd)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (win_ready) win_valid_d = 1'b0;
    if (acc) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
      // shift left one column, new right column enters top to bottom
      win_d = {pix_in, win_q[8:7],
               lb1_rd, win_q[5:4],
               lb2_rd, win_q[2:1]};
      if (qual) begin
        win_valid_d = 1'b1;
        win_last_d  = row_end && col_end;
      end
      unique case (state_q)
        S_FILL:  if (row_q == ROW_PRE && col_end) state_d = S_RUN;
        S_RUN:   if (row_end && col_end) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = !rst && win_valid_q && win_ready && win_last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: ramp frames, stall,
// back-to-back frames, mid-frame reset and random gaps.
module tb_conv_window_feeder;

  localparam int W  = 8;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int WB = 9 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [WB-1:0] win;
  logic          win_valid;
  logic          win_ready;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_feeder #(
    .width(W),
    .img_w(IW),
    .img_h(IH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_done(frame_done)
  );

  int errs = 0;
  int checks = 0;

  logic [W-1:0]  img [2][IH][IW];
  logic [WB-1:0] exp_q [$];
  bit            last_q [$];
  logic [WB-1:0] got [$];
  logic [WB-1:0] stall_exp;
  bit            stall_now;
  int fd_cnt, mf, mr, mc, npix, cyc_n, first_q_cyc, first_v_cyc;
  int stall_cnt;

  task automatic chk(input string tag, input logic [WB-1:0] obs,
                     input logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] pk9(
    input int a0, input int a1, input int a2,
    input int a3, input int a4, input int a5,
    input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4),
            8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // reference window: straight from the frame array
  function automatic logic [WB-1:0] expw(input int f, input int r,
                                         input int c);
    logic [WB-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(3*i+j)*W +: W] = img[f][r-2+i][c-2+j];
    return v;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    last_q.delete();
    got.delete();
    fd_cnt = 0; mf = 0; mr = 0; mc = 0; npix = 0; cyc_n = 0;
    first_q_cyc = -1; first_v_cyc = -1; stall_cnt = 0;
    stall_now = 1'b0;
  endtask

  task automatic cyc();
    bit acc, hs, lst;
    logic [WB-1:0] tmp;
    #4;
    acc = pix_valid && pix_ready;
    hs  = win_valid && win_ready;
    chk1("pix_ready", pix_ready, !win_valid || win_ready);
    chk1("win_valid", win_valid, exp_q.size() != 0);
    if (win_valid && first_v_cyc < 0) first_v_cyc = cyc_n;
    if (stall_now) begin
      chk("stall_win", win, stall_exp);
      chk1("stall_pix_ready", pix_ready, 1'b0);
    end
    if (hs && exp_q.size() != 0) begin
      chk("win", win, exp_q[0]);
      chk1("frame_done", frame_done, last_q[0]);
      got.push_back(win);
      tmp = exp_q.pop_front();
      lst = last_q.pop_front();
    end else begin
      chk1("frame_done_idle", frame_done, 1'b0);
    end
    if (frame_done) fd_cnt++;
    if (acc) begin
      if (mr >= 2 && mc >= 2) begin
        exp_q.push_back(expw(mf, mr, mc));
        last_q.push_back(mr == IH-1 && mc == IW-1);
        if (first_q_cyc < 0) first_q_cyc = cyc_n;
      end
      npix++;
      mc++;
      if (mc == IW) begin
        mc = 0;
        mr++;
        if (mr == IH) begin
          mr = 0;
          mf++;
        end
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int nfr, input bit rnd,
                     input int stall_win, input int stop_pix);
    int budget;
    bit more;
    budget = 0;
    while (budget < 3000) begin
      more = (mf < nfr) && (stop_pix == 0 || npix < stop_pix);
      if (!more && (exp_q.size() == 0 || stop_pix != 0)) break;
      pix_valid = more && (!rnd || $urandom_range(3) != 0);
      if (more) pix_in = img[mf][mr][mc];
      else pix_in = '0;
      win_ready = !rnd || $urandom_range(2) != 0;
      stall_now = 1'b0;
      if (stall_win >= 0 && got.size() == stall_win &&
          exp_q.size() != 0 && stall_cnt < 3) begin
        win_ready = 1'b0;
        stall_now = 1'b1;
        stall_cnt++;
      end
      cyc();
      budget++;
    end
    stall_now = 1'b0;
    pix_valid = 1'b0;
    chk1("no_timeout", budget < 3000, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    pix_in = '0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        img[0][r][c] = 8'(8*r + c);
        img[1][r][c] = 8'(8*r + c + 100);
      end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("rst_win_valid", win_valid, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk("rst_win", win, '0);
    rst = 1'b0;
    #1;
    chk1("rst_pix_ready", pix_ready, 1'b1);

    // continuous ramp frame
    reset_model();
    run(1, 1'b0, -1, 0);
    chki("ramp_count", got.size(), 36);
    chk("ramp_first", got[0], pk9(0,1,2,8,9,10,16,17,18));
    chk("ramp_last", got[35],
        pk9(45,46,47,53,54,55,61,62,63));
    chk("row_end_win", got[5], pk9(5,6,7,13,14,15,21,22,23));
    chk("row_wrap_win", got[6], pk9(8,9,10,16,17,18,24,25,26));
    chki("ramp_fd", fd_cnt, 1);
    chki("latency", first_v_cyc - first_q_cyc, 1);

    // consumer stalls on the window of pixel 29
    reset_model();
    stall_exp = pk9(11,12,13,19,20,21,27,28,29);
    run(1, 1'b0, 9, 0);
    chki("stall_cycles", stall_cnt, 3);
    chki("stall_count", got.size(), 36);
    chk("stall_last", got[35],
        pk9(45,46,47,53,54,55,61,62,63));
    chki("stall_fd", fd_cnt, 1);

    // two frames back to back
    reset_model();
    run(2, 1'b0, -1, 0);
    chki("b2b_count", got.size(), 72);
    chk("b2b_first2", got[36],
        pk9(100,101,102,108,109,110,116,117,118));
    chki("b2b_fd", fd_cnt, 2);

    // reset after pixel 30 with handshakes pending
    reset_model();
    run(1, 1'b0, -1, 31);
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'hAA;
    win_ready = 1'b1;
    #4;
    chk1("rst_prio_fd", frame_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    chk1("midrst_win_valid", win_valid, 1'b0);
    chk1("midrst_pix_ready", pix_ready, 1'b1);
    chk("midrst_win", win, '0);
    reset_model();
    run(1, 1'b0, -1, 0);
    chki("midrst_count", got.size(), 36);
    chk("midrst_first", got[0], pk9(0,1,2,8,9,10,16,17,18));
    chk("midrst_last", got[35],
        pk9(45,46,47,53,54,55,61,62,63));
    chki("midrst_fd", fd_cnt, 1);

    // random pixels with random gaps on both sides
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[0][r][c] = 8'($urandom);
    reset_model();
    run(1, 1'b1, -1, 0);
    chki("rand_count", got.size(), 36);
    chki("rand_fd", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
